// File: rtl/sop_lut_eval_pkg.sv
// Shared constants for the programmable sum-of-products evaluator.
//   ST_IDLE / ST_LOAD  : load FSM state encodings (1 bit)
//   DEFAULT_TABLE_N4   : power-on minterm table for 4 inputs
//                        (minterms 2, 4, 7, 11, 12)
package sop_lut_eval_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam logic [15:0] DEFAULT_TABLE_N4 = 16'h1894;

endpackage

// File: rtl/sop_lut_eval_if.sv
// Evaluation channel of sop_lut_eval.
//   in_valid / in_ready : request handshake. A request (x) transfers on a
//                         rising clk edge where in_valid && in_ready are both
//                         high; the source must hold in_valid and x stable
//                         until that edge. in_ready never depends on in_valid.
//   x                   : input vector, x[N-1] is the minterm index MSB
//   out_valid / f       : one-cycle result pulse; no backpressure
// master = request source / result sink, slave = evaluator.
interface sop_lut_eval_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x;
    logic         out_valid;
    logic         f;

    modport master (output in_valid, x, input in_ready, out_valid, f);
    modport slave  (input in_valid, x, output in_ready, out_valid, f);
endinterface

// File: rtl/sop_table_loader.sv
// Serial minterm-table loader.
//   clk, rst       : clock, asynchronous active-high reset
//   load_start     : begin (IDLE) or restart (LOAD) a table load
//   load_valid     : load_bit is valid this cycle
//   load_bit       : next table bit, minterm 0 first
//   busy_o         : high while in LOAD
//   commit_o       : one-cycle strobe, high in the cycle the last bit is taken
//   table_o        : full table including the bit being written; only
//                    meaningful while commit_o is high
module sop_table_loader
    import sop_lut_eval_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_bit,
    output logic              busy_o,
    output logic              commit_o,
    output logic [2**N-1:0]   table_o
);

    localparam int DEPTH = 2**N;
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DEPTH-1:0] shadow_q, shadow_d;
    logic [DEPTH-1:0] shadow_wr;

    // Shadow with the current bit merged in, so the commit carries the last
    // bit without waiting a cycle.
    always_comb begin
        shadow_wr            = shadow_q;
        shadow_wr[bit_cnt_q] = load_bit;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        commit_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    shadow_d  = '0;
                end
            end
            ST_LOAD: begin
                // Restart wins over a bit offered in the same cycle.
                if (load_start) begin
                    bit_cnt_d = '0;
                    shadow_d  = '0;
                end else if (load_valid) begin
                    shadow_d = shadow_wr;
                    if (bit_cnt_q == '1) begin
                        commit_o  = 1'b1;
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shadow_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    assign busy_o  = (state_q == ST_LOAD);
    assign table_o = shadow_wr;

endmodule

// File: rtl/sop_lut_eval.sv
// Registered, programmable N-input sum-of-products evaluator.
//   clk, rst        : clock, asynchronous active-high reset
//   ev (slave)      : in_valid/in_ready/x request, out_valid/f result
//   load_start/load_valid/load_bit : serial table load port
//   load_busy       : table load in progress (evaluations stalled)
//   count_clr       : synchronous clear of hit_count (beats a same-cycle hit)
//   hit_count       : saturating count of results with f = 1
module sop_lut_eval
    import sop_lut_eval_pkg::*;
#(
    parameter int                N             = 4,
    parameter logic [2**N-1:0]   DEFAULT_TABLE = DEFAULT_TABLE_N4,
    parameter int                CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    sop_lut_eval_if.slave    ev,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_busy,
    input  logic             count_clr,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [CNT_W-1:0] HIT_MAX = '1;
    localparam logic [CNT_W-1:0] HIT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2**N-1:0] table_q;
    logic            out_valid_q;
    logic            f_q;
    logic [CNT_W-1:0] hit_q;

    logic            load_commit;
    logic [2**N-1:0] load_table;
    logic            accept;

    sop_table_loader #(.N(N)) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .busy_o     (load_busy),
        .commit_o   (load_commit),
        .table_o    (load_table)
    );

    assign ev.in_ready = ~load_busy;
    assign accept      = ev.in_valid & ev.in_ready;

    // Accept and commit are mutually exclusive (in_ready is low in LOAD), so
    // an accepted evaluation always reads the table as it was before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= DEFAULT_TABLE;
        end else if (load_commit) begin
            table_q <= load_table;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                f_q <= table_q[ev.x];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
        end else if (count_clr) begin
            hit_q <= '0;
        end else if (out_valid_q && f_q && (hit_q != HIT_MAX)) begin
            hit_q <= hit_q + HIT_ONE;
        end
    end

    assign ev.out_valid = out_valid_q;
    assign ev.f         = f_q;
    assign hit_count    = hit_q;

endmodule

// File: doc/sop_lut_eval.md
Name: sop_lut_eval

Overview:
- Registered, programmable sum-of-products evaluator for an N-input Boolean function. The function is held as a 2^N-bit minterm table, where bit k = 1 means minterm k is in the SOP.
- Successor to the fixed 4-input SOP gate network in the P01 exercises. Inputs are accepted via a valid/ready handshake and the result is returned one cycle later.
- The table can be reprogrammed at runtime through a serial load port. A saturating counter records how many evaluations returned 1.

Parameters:
- N, 4, number of function inputs; table depth is 2^N.
- DEFAULT_TABLE, 16'h1894, minterm table loaded at reset (minterms 2, 4, 7, 11, 12); width 2^N.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector x is presented.
- in_ready  out  1  block can accept an evaluation this cycle.
- x  in  N  input vector; x[N-1] is the MSB of the minterm index (a = MSB for N=4).
- out_valid  out  1  f is valid this cycle (1-cycle pulse).
- f  out  1  registered function result.
- load_start  in  1  begin or restart serial table load.
- load_valid  in  1  load_bit is valid.
- load_bit  in  1  next table bit, minterm 0 first.
- load_busy  out  1  load in progress.
- count_clr  in  1  synchronous clear of hit_count.
- hit_count  out  CNT_W  number of evaluations with f=1, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - table = DEFAULT_TABLE; state = IDLE.
  - in_ready = 1; load_busy = 0.
  - out_valid = 0; f = 0; hit_count = 0.
  - Load bit counter = 0; shadow register = 0.
- State machine has two states, IDLE and LOAD.
  - in_ready = (state == IDLE).
  - load_busy = (state == LOAD).
- IDLE → LOAD on load_start. The bit counter and shadow register are cleared.
- In LOAD, each cycle with load_valid = 1:
  - shadow[bit_cnt] = load_bit, then bit_cnt increments.
  - On the cycle the bit at index 2^N − 1 is written, the table is committed on the same edge, using the full shadow including that last bit. State returns to IDLE and bit_cnt goes to 0.
  - The first evaluation using the new table is accepted on the next cycle.
- load_start asserted while in LOAD restarts the load: bit_cnt = 0, shadow cleared, load_valid that cycle ignored. The table is not modified.
- load_valid while in IDLE is ignored.
- Evaluation:
  - An input is accepted when in_valid & in_ready.
  - On the next edge: out_valid = 1 and f = table[x], using the table value before that edge.
  - Otherwise out_valid = 0 and f holds its last value.
  - Latency is 1 cycle; throughput is 1 per cycle in IDLE. There is no output backpressure.
- Simultaneous in_valid and load_start in IDLE: the evaluation is accepted using the old table, and the state moves to LOAD.
- in_valid while in LOAD is not accepted; the source must hold it.
- Hit counter:
  - Increments on each cycle where out_valid & f.
  - Saturates at 2^CNT_W − 1; no wrap.
  - count_clr has priority over increment: the counter reads 0 on the following cycle even if a hit occurs in the same cycle.
- Reset mid-load aborts the load. The table returns to DEFAULT_TABLE and partial shadow contents are discarded.
- Reset mid-evaluation drops the pending result; out_valid = 0.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE = 1'b0, LOAD = 1'b1;
  - the DEFAULT_TABLE constant for N = 4 (16'h1894).
- One sub-module: sop_table_loader. It contains the load FSM, bit counter, shadow register and commit strobe. Its outputs are the commit pulse, the committed table value and busy.
- Top level holds the table register, evaluation pipeline register and hit counter.

Test Plan:
- After reset, sweep x = 0..15 one per cycle (each evaluation cycle has in_valid = 1) → f = 1 exactly for x = 2, 4, 7, 11, 12, each one cycle after its x. Final hit_count = 5.
- Load table 16'h8001: load_start, then 16 bits LSB first → load_busy high for 16 cycles, then IDLE. Evaluating x = 0, 15, 5 → f = 1, 1, 0.
- in_valid = 1 with x = 4 during LOAD → in_ready = 0, no out_valid. Accepted on the first IDLE cycle after commit, with f = new_table[4].
- Same-cycle in_valid(x = 2) and load_start in IDLE → f = 1 from the old table, and load_busy = 1 the next cycle.
- load_start after 7 bits, then 16 fresh bits of 16'hFFFF → table = 16'hFFFF, with no trace of the first 7 bits.
- CNT_W = 3, 10 consecutive hits → hit_count saturates at 7. count_clr on the same cycle as a hit → 0.
- rst asserted after 5 load bits → table = 16'h1894, load_busy = 0, hit_count = 0, asynchronously.
